// File: rtl/inst_queue_pkg.sv
// Shared configuration for the instruction queue: data widths, default depth
// and the layout of one queue entry.
package inst_queue_pkg;

    localparam int INST_W   = 32;
    localparam int PC_W     = 32;
    localparam int IQ_DEPTH = 16;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } iq_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Circular instruction queue between fetch and issue. It has no bypass, so the
// head data is always read straight out of storage.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_valid,
    input  logic [INST_W-1:0] inst_from_if,
    input  logic [PC_W-1:0]   pc_from_if,
    output logic              queue_full,
    input  logic              issue_ready,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_to_issue,
    output logic [PC_W-1:0]   pc_to_issue,
    input  logic              jump_flag
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    iq_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic             push;
    logic             pop;
    iq_entry_t        head_entry;

    // Status comes only from the registered count, so fetch/issue handshakes
    // never see a combinational path through this block.
    assign queue_full = (count == FULL_COUNT);
    assign inst_valid = (count != '0);

    assign push = rdy && if_valid   && !queue_full && !jump_flag;
    assign pop  = rdy && issue_ready && inst_valid && !jump_flag;

    assign head_entry    = mem[head];
    assign inst_to_issue = head_entry.inst;
    assign pc_to_issue   = head_entry.pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (jump_flag) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                // Pointers wrap naturally because they are exactly log2(DEPTH) wide.
                if (push) tail <= tail + 1'b1;
                if (pop)  head <= head + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= '{inst: inst_from_if, pc: pc_from_if};
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: a reference queue tracks every accepted
// push and each pop is compared against its front entry.
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int DEPTH = 16;

    logic              clk;
    logic              rst;
    logic              rdy;
    logic              if_valid;
    logic [INST_W-1:0] inst_from_if;
    logic [PC_W-1:0]   pc_from_if;
    logic              queue_full;
    logic              issue_ready;
    logic              inst_valid;
    logic [INST_W-1:0] inst_to_issue;
    logic [PC_W-1:0]   pc_to_issue;
    logic              jump_flag;

    iq_entry_t sb [$];
    int        num_vectors;
    int        num_miscompares;
    logic [PC_W-1:0] next_pc;

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .if_valid     (if_valid),
        .inst_from_if (inst_from_if),
        .pc_from_if   (pc_from_if),
        .queue_full   (queue_full),
        .issue_ready  (issue_ready),
        .inst_valid   (inst_valid),
        .inst_to_issue(inst_to_issue),
        .pc_to_issue  (pc_to_issue),
        .jump_flag    (jump_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        num_vectors++;
        if (observed !== expected) begin
            num_miscompares++;
            $display("[TB] FAIL %s: observed %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkStatus();
        checkOutput("inst_valid", 64'(inst_valid), 64'(sb.size() != 0));
        checkOutput("queue_full", 64'(queue_full), 64'(sb.size() == DEPTH));
        if (sb.size() != 0) begin
            checkOutput("head_inst", 64'(inst_to_issue), 64'(sb[0].inst));
            checkOutput("head_pc", 64'(pc_to_issue), 64'(sb[0].pc));
        end
    endtask

    // Called just after a rising edge; drives one cycle of inputs, updates the
    // model, then checks the outputs after the next edge.
    task automatic applyStimulus(input logic ifv, input logic [INST_W-1:0] inst, input logic [PC_W-1:0] pc,
                                 input logic ir, input logic jf, input logic rd);
        iq_entry_t popped;
        bit        do_push;
        rdy          = rd;
        if_valid     = ifv;
        inst_from_if = inst;
        pc_from_if   = pc;
        issue_ready  = ir;
        jump_flag    = jf;
        #1;
        do_push = rd && !jf && ifv && (sb.size() < DEPTH);
        if (rd && !jf && ir && sb.size() != 0) begin
            popped = sb.pop_front();
            checkOutput("pop_inst", 64'(inst_to_issue), 64'(popped.inst));
            checkOutput("pop_pc", 64'(pc_to_issue), 64'(popped.pc));
        end
        if (do_push) sb.push_back('{inst: inst, pc: pc});
        if (rd && jf) sb.delete();
        @(posedge clk);
        #1;
        checkStatus();
    endtask

    task automatic pushPc(input logic ir);
        applyStimulus(1'b1, 32'hA000_0000 ^ next_pc, next_pc, ir, 1'b0, 1'b1);
        next_pc += 4;
    endtask

    initial begin
        num_vectors     = 0;
        num_miscompares = 0;
        next_pc         = '0;
        rst          = 1'b0;
        rdy          = 1'b1;
        if_valid     = 1'b0;
        inst_from_if = '0;
        pc_from_if   = '0;
        issue_ready  = 1'b0;
        jump_flag    = 1'b0;

        #12;
        checkOutput("reset_valid", 64'(inst_valid), 64'd0);
        checkOutput("reset_full", 64'(queue_full), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkStatus();

        // Single push, one cycle of no-bypass latency, then pop.
        applyStimulus(1'b1, 32'h0000_0013, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("single_inst", 64'(inst_to_issue), 64'h13);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        checkOutput("single_empty", 64'(inst_valid), 64'd0);

        // Fill to full, ignore a 17th push, then push+pop together while full.
        next_pc = '0;
        for (int i = 0; i < DEPTH; i++) pushPc(1'b0);
        checkOutput("fill_full", 64'(queue_full), 64'd1);
        pushPc(1'b0);
        pushPc(1'b1);
        checkOutput("full_pushpop", 64'(queue_full), 64'd0);
        pushPc(1'b0);
        checkOutput("refill_full", 64'(queue_full), 64'd1);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);

        // Flush with five entries while both handshakes are active.
        for (int i = 0; i < 5; i++) pushPc(1'b0);
        applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h1234, 1'b1, 1'b1, 1'b1);
        checkOutput("flush_valid", 64'(inst_valid), 64'd0);

        // Freeze with rdy low while toggling inputs, then async reset mid-cycle.
        for (int i = 0; i < 7; i++) pushPc(1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus(i[0], 32'h5555_0000 + i, 32'h9000 + i, ~i[0], i[0], 1'b0);
        rdy = 1'b1; if_valid = 1'b0; issue_ready = 1'b0; jump_flag = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_valid", 64'(inst_valid), 64'd0);
        checkOutput("async_full", 64'(queue_full), 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkStatus();

        // Wrap-around: 20 pushes with pops on alternate cycles, then drain.
        for (int i = 0; i < 20; i++) pushPc(i[0]);
        while (sb.size() != 0) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);

        // Random traffic including flushes and freezes.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom, next_pc,
                          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 30) == 0),
                          1'($urandom_range(0, 7) != 0));
            next_pc += 4;
        end
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
        $finish;
    end

endmodule
